vred_accum_unit: RTL and testbench
==================================

Name: vred_accum_unit

Overview:
- Multi-beat vector reduction unit: folds a stream of DATA_WIDTH-bit beats into one scalar, seeded by a scalar operand.
- Ops: sum, min/max (signed and unsigned), and, or, xor, at SEW 8/16/32/64.
- Successor to the single-beat pairwise reduce block. Adds streaming accumulation over arbitrary VL, per-element masking and a valid/ready result handshake.
- Sits in vALU behind the operand-fetch stage; the result goes to the writeback arbiter.

Parameters:
- DATA_WIDTH, 64, beat width in bits; power of 2, range 64..512.
- RESP_DATA_WIDTH, 64, result width in bits.
- SEW_WIDTH, 2, width of the sew field.
- OP_WIDTH, 3, width of the op field.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches op, sew and seed
- op  in  OP_WIDTH  000 sum, 001 minu, 010 min, 011 maxu, 100 max, 101 and, 110 or, 111 xor
- sew  in  SEW_WIDTH  element width = 8<<sew bits
- seed  in  RESP_DATA_WIDTH  scalar initial value; only the low SEW bits are used
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid and in_ready are both high
- in_last  in  1  marks the final beat
- in_data  in  DATA_WIDTH  packed elements; element i occupies bits [i*SEW +: SEW]
- in_mask  in  DATA_WIDTH/8  bit i enables element i; bits at or above DATA_WIDTH/SEW are ignored
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  result consumed
- out_data  out  RESP_DATA_WIDTH  result; low SEW bits hold the value, upper bits are zero
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: asynchronous, active-low (rst = 0). Clears state to IDLE and forces in_ready=0, out_valid=0, out_data=0, busy=0.
- Reset asserted mid-operation aborts it. Partial results are discarded.
- States and transitions:
  - IDLE: start moves to ACCUM. The latched seed is truncated to SEW bits and becomes the accumulator. start outside IDLE is ignored.
  - ACCUM: in_ready=1. Each accepted beat is reduced through a lane tree into a stage register (1 cycle), then combined with the accumulator the next cycle. Accepting a beat with in_last=1 drops in_ready the following cycle and moves to DRAIN.
  - DRAIN: waits for the stage register to retire (exactly 1 cycle), then moves to DONE.
  - DONE: out_valid=1 and out_data stable. The out_valid and out_ready handshake returns to IDLE the same edge; out_valid is low the next cycle.
- Latency: out_valid rises 2 cycles after the in_last beat handshake. Back-to-back beats are accepted every cycle.
- Masked-out elements are replaced by the op identity before the tree:
  - sum, or, xor, maxu: 0
  - and, minu: all ones
  - min: the most positive signed value
  - max: the most negative signed value
- A beat with in_mask all zero leaves the accumulator unchanged. A reduction with no active elements returns the seed.
- Arithmetic:
  - sum wraps modulo 2^SEW.
  - min and max use two's-complement compare at SEW.
  - minu and maxu use unsigned compare.
  - Ties keep the accumulator value.
- in_valid while in_ready=0 has no effect. The source must hold the beat until it is accepted.
- op and sew are sampled only at start. Changes to either during ACCUM are ignored.
- Unsupported sew (elements wider than RESP_DATA_WIDTH) is treated as sew=3.

Optional Feature:
- Macro VRED_MINMAX_EN.
- Defined: comparator lanes are built and op codes 001..100 perform min/max as specified.
- Undefined: no comparators are synthesised. Codes 001..100 still consume beats with the normal handshake and timing, and out_data = seed truncated to SEW.

Test Plan:
- sew=0, op=sum, seed=0x05, one beat of bytes 01..08, mask=0xFF, last -> out_data=0x29, 2 cycles after the beat.
- sew=2, op=min, seed=0x00000010, beats {-3,7}, {20,-9} (second with last), mask=0x03 -> out_data=0xFFFFFFF7.
- sew=1, op=maxu, seed=0x0001, beat {0xFFFF, 0x0002, 0x8000, 0x0003}, mask=0b0010 -> out_data=0x0002, since masked 0xFFFF is ignored.
- sew=3, op=and, seed=0xFFFF_FFFF_FFFF_FFFF, three beats with mask=0 -> out_data equals the seed; out_valid held 4 cycles with out_ready=0, then cleared after the handshake.
- Reset pulled low in ACCUM after 2 beats -> out_valid=0, busy=0 immediately. A following start with op=xor, seed=0, beat 0x0F0F, sew=0 -> 0x00.
- start pulsed during DRAIN with seed=0x77 -> ignored; the in-flight result is unaffected.

Source files
------------

// File: rtl/vred_accum_unit.sv
// Multi-beat vector reduction: folds DATA_WIDTH-bit beats into one SEW-wide scalar seeded by an operand.
// Define VRED_MINMAX_EN to build the min/max comparator lanes; without it those ops return the seed.
module vred_accum_unit #(
  parameter int DATA_WIDTH      = 64,
  parameter int RESP_DATA_WIDTH = 64,
  parameter int SEW_WIDTH       = 2,
  parameter int OP_WIDTH        = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [OP_WIDTH-1:0]        op,
  input  logic [SEW_WIDTH-1:0]       sew,
  input  logic [RESP_DATA_WIDTH-1:0] seed,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic [DATA_WIDTH/8-1:0]    in_mask,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [RESP_DATA_WIDTH-1:0] out_data,
  output logic                       busy
);

  localparam int EW = 64;
  localparam int NL = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
  typedef enum logic [2:0] {
    OP_SUM, OP_MINU, OP_MIN, OP_MAXU, OP_MAX, OP_AND, OP_OR, OP_XOR
  } op_t;

  function automatic logic [EW-1:0] sew_mask(input logic [1:0] s);
    case (s)
      2'd0:    return 64'h0000_0000_0000_00FF;
      2'd1:    return 64'h0000_0000_0000_FFFF;
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [EW-1:0] sign_bit(input logic [1:0] s);
    return sew_mask(s) ^ (sew_mask(s) >> 1);
  endfunction

  function automatic logic [EW-1:0] identity(input op_t o, input logic [1:0] s);
    case (o)
      OP_AND, OP_MINU: return sew_mask(s);
      OP_MIN:          return sew_mask(s) >> 1;
      OP_MAX:          return sign_bit(s);
      default:         return '0;
    endcase
  endfunction

  // 'a' is the retained side: on a tie the result is 'a', which keeps the accumulator.
  function automatic logic [EW-1:0] combine(input logic [EW-1:0] a, input logic [EW-1:0] b,
                                            input op_t o, input logic [1:0] s);
    case (o)
      OP_SUM:  return (a + b) & sew_mask(s);
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
`ifdef VRED_MINMAX_EN
      OP_MINU: return (b < a) ? b : a;
      OP_MAXU: return (b > a) ? b : a;
      OP_MIN:  return ((b ^ sign_bit(s)) < (a ^ sign_bit(s))) ? b : a;
      OP_MAX:  return ((b ^ sign_bit(s)) > (a ^ sign_bit(s))) ? b : a;
`endif
      default: return a;
    endcase
  endfunction

  state_t          state, state_nxt;
  op_t             op_q;
  logic [1:0]      sew_q, sew_eff;
  logic [EW-1:0]   acc, stage;
  logic            stage_vld;
  logic            beat_acc;
  logic [EW-1:0]   leaf [NL];
  logic [EW-1:0]   node [NL-1];

  assign beat_acc = in_valid && (state == ACCUM);

  always_comb begin
    sew_eff = 2'd3;
    if ((32'(sew) < 3) && ((8 << sew) <= RESP_DATA_WIDTH)) sew_eff = sew[1:0];
  end

  // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < NL; i++) begin
      leaf[i] = identity(op_q, sew_q);
      if ((i < (NL >> sew_q)) && in_mask[i])
        leaf[i] = EW'(in_data >> (i << (3 + sew_q))) & sew_mask(sew_q);
    end
  end

  // Heap-ordered lane tree: node k has children 2k+1 and 2k+2; indices >= NL-1 are leaves.
  for (genvar k = 0; k < NL - 1; k++) begin : g_tree
    logic [EW-1:0] l_in, r_in;
    if (2 * k + 1 >= NL - 1) begin : g_leaf
      assign l_in = leaf[2*k+1-(NL-1)];
      assign r_in = leaf[2*k+2-(NL-1)];
    end else begin : g_node
      assign l_in = node[2*k+1];
      assign r_in = node[2*k+2];
    end
    assign node[k] = combine(l_in, r_in, op_q, sew_q);
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      op_q      <= OP_SUM;
      sew_q     <= 2'd0;
      acc       <= '0;
      stage     <= '0;
      stage_vld <= 1'b0;
    end else begin
      state     <= state_nxt;
      stage_vld <= beat_acc;
      if (beat_acc) stage <= node[0];
      if (state == IDLE && start) begin
        op_q  <= op_t'(op);
        sew_q <= sew_eff;
        acc   <= EW'(seed) & sew_mask(sew_eff);
      end else if (stage_vld) begin
        acc <= combine(acc, stage, op_q, sew_q);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (beat_acc && in_last) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    out_data  = (state == DONE) ? RESP_DATA_WIDTH'(acc) : '0;
  end

endmodule

// File: tb/tb_vred_accum_unit.sv
// Self-checking bench for vred_accum_unit: directed scenarios plus randomized reductions against a queue-free arithmetic model.
module tb_vred_accum_unit;

  localparam int DW = 64;
  localparam int RW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op = '0;
  logic [1:0]    sew = '0;
  logic [RW-1:0] seed = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DW/8-1:0] in_mask = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [RW-1:0] out_data;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [63:0] bd [32];
  logic [7:0]  bm [32];

  vred_accum_unit #(.DATA_WIDTH(DW), .RESP_DATA_WIDTH(RW), .SEW_WIDTH(2), .OP_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .sew(sew), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_data(in_data),
    .in_mask(in_mask), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint sx(input logic [63:0] x, input int esz);
    return $signed(x << (64 - esz)) >>> (64 - esz);
  endfunction

  // Reference: walk every active element of every beat and fold it into the seed.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [1:0] s,
                                        input logic [63:0] sd, input int nb);
    int esz = 8 << s;
    int n = 64 / esz;
    logic [63:0] m = (esz == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << esz) - 64'd1);
    logic [63:0] acc = sd & m;
    logic [63:0] v;
    for (int b = 0; b < nb; b++) begin
      for (int e = 0; e < n; e++) begin
        if (bm[b][e]) begin
          v = (bd[b] >> (e * esz)) & m;
          case (o)
            3'd0: acc = (acc + v) & m;
            3'd1: if (v < acc) acc = v;
            3'd2: if (sx(v, esz) < sx(acc, esz)) acc = v;
            3'd3: if (v > acc) acc = v;
            3'd4: if (sx(v, esz) > sx(acc, esz)) acc = v;
            3'd5: acc = acc & v;
            3'd6: acc = acc | v;
            default: acc = acc ^ v;
          endcase
        end
      end
    end
`ifndef VRED_MINMAX_EN
    if (o inside {3'd1, 3'd2, 3'd3, 3'd4}) acc = sd & m;
`endif
    return acc;
  endfunction

  // Drives one full reduction from bd/bm; returns the result and cycles from last handshake to out_valid.
  task automatic run_red(input logic [2:0] op_i, input logic [1:0] sew_i, input logic [63:0] seed_i,
                         input int nb, input int hold, input bit gaps, input bit drain_start,
                         output logic [63:0] res, output int lat);
    int g;
    int hs;
    res = '0;
    lat = -1;
    hs = 0;
    @(negedge clk);
    op = op_i; sew = sew_i; seed = seed_i; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); sew = 2'($urandom); seed = {$urandom, $urandom};
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_start got=%b exp=1", busy); end
    for (int b = 0; b < nb; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0; in_data = {$urandom, $urandom}; in_last = 1'b1;
        @(negedge clk);
      end
      in_valid = 1'b1; in_data = bd[b]; in_mask = bm[b]; in_last = (b == nb - 1);
      g = 0;
      while (in_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
      checks++;
      if (g >= 20) begin
        failures++; $display("FAIL in_ready_timeout beat=%0d got=%b exp=1", b, in_ready);
        in_valid = 1'b0; in_last = 1'b0;
        return;
      end
      hs = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = {$urandom, $urandom};
    if (drain_start) begin
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        failures++; $display("FAIL drain_state in_ready=%b busy=%b exp in_ready=0 busy=1", in_ready, busy);
      end
      seed = 64'h77; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    g = 0;
    while (out_valid !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    checks++;
    if (g >= 20) begin
      failures++; $display("FAIL out_valid_timeout got=%b exp=1", out_valid);
      return;
    end
    lat = cyc - hs;
    res = out_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== res) begin
        failures++; $display("FAIL out_hold cyc=%0d valid=%b data=%h exp valid=1 data=%h", h, out_valid, out_data, res);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL after_handshake valid=%b busy=%b exp 0 0", out_valid, busy);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state in_ready=%b out_valid=%b out_data=%h busy=%b exp all zero", in_ready, out_valid, out_data, busy);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset busy=%b in_ready=%b out_valid=%b exp 0", busy, in_ready, out_valid);
    end
  endtask

  task automatic check_result(input string name, input logic [63:0] got, input logic [63:0] exp, input int lat);
    checks++;
    if (got !== exp) begin failures++; $display("FAIL %s data got=%h exp=%h", name, got, exp); end
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL %s latency got=%0d exp=2", name, lat); end
  endtask

  task automatic test_sum_bytes();
    logic [63:0] r; int lat;
    bd[0] = 64'h0807_0605_0403_0201; bm[0] = 8'hFF;
    run_red(3'd0, 2'd0, 64'h05, 1, 0, 1'b0, 1'b0, r, lat);
    check_result("sum_bytes", r, 64'h29, lat);
  endtask

  task automatic test_min_signed();
    logic [63:0] r, e; int lat;
    bd[0] = {32'd7, 32'hFFFF_FFFD};  bm[0] = 8'h03;
    bd[1] = {32'hFFFF_FFF7, 32'd20}; bm[1] = 8'h03;
    run_red(3'd2, 2'd2, 64'h10, 2, 1, 1'b0, 1'b0, r, lat);
`ifdef VRED_MINMAX_EN
    e = 64'hFFFF_FFF7;
`else
    e = 64'h10;
`endif
    check_result("min_signed", r, e, lat);
  endtask

  task automatic test_maxu_masked();
    logic [63:0] r, e; int lat;
    bd[0] = {16'h0003, 16'h8000, 16'h0002, 16'hFFFF}; bm[0] = 8'b0000_0010;
    run_red(3'd3, 2'd1, 64'h0001, 1, 0, 1'b0, 1'b0, r, lat);
`ifdef VRED_MINMAX_EN
    e = 64'h0002;
`else
    e = 64'h0001;
`endif
    check_result("maxu_masked", r, e, lat);
  endtask

  task automatic test_and_empty_hold();
    logic [63:0] r; int lat;
    for (int b = 0; b < 3; b++) begin bd[b] = {$urandom, $urandom}; bm[b] = 8'h00; end
    run_red(3'd5, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 3, 4, 1'b0, 1'b0, r, lat);
    check_result("and_empty", r, 64'hFFFF_FFFF_FFFF_FFFF, lat);
  endtask

  task automatic test_reset_abort();
    logic [63:0] r; int lat;
    @(negedge clk);
    op = 3'd0; sew = 2'd0; seed = 64'h3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 64'h1111_1111_1111_1111; in_mask = 8'hFF;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_abort out_valid=%b busy=%b in_ready=%b exp 0", out_valid, busy, in_ready);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bd[0] = 64'h0000_0000_0000_0F0F; bm[0] = 8'hFF;
    run_red(3'd7, 2'd0, 64'h0, 1, 0, 1'b0, 1'b0, r, lat);
    check_result("xor_after_abort", r, 64'h00, lat);
  endtask

  task automatic test_start_in_drain();
    logic [63:0] r; int lat;
    bd[0] = 64'h0000_0000_0102_0304; bm[0] = 8'h0F;
    bd[1] = 64'h0000_0000_0000_0010; bm[1] = 8'h01;
    run_red(3'd0, 2'd0, 64'h01, 2, 1, 1'b0, 1'b1, r, lat);
    check_result("start_in_drain", r, 64'h1B, lat);
  endtask

  task automatic test_random();
    logic [63:0] r, e, sd; logic [2:0] o; logic [1:0] s; int nb, lat;
    for (int t = 0; t < 60; t++) begin
      o = 3'($urandom); s = 2'($urandom); sd = {$urandom, $urandom};
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        bd[b] = {$urandom, $urandom};
        bm[b] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      end
      e = model(o, s, sd, nb);
      run_red(o, s, sd, nb, $urandom_range(0, 3), 1'b1, 1'b0, r, lat);
      checks++;
      if (r !== e) begin
        failures++; $display("FAIL random t=%0d op=%0d sew=%0d got=%h exp=%h", t, o, s, r, e);
      end
      checks++;
      if (lat !== 2) begin failures++; $display("FAIL random_latency t=%0d got=%0d exp=2", t, lat); end
    end
  endtask

  initial begin
    test_reset();
    test_sum_bytes();
    test_min_signed();
    test_maxu_masked();
    test_and_empty_hold();
    test_reset_abort();
    test_start_in_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
